// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vend_pkg
// Purpose  : Shared types and default constants for the vend dispense arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package vend_pkg;

    localparam int c_num_req     = 2;
    localparam int c_timeout_def = 16;
    localparam int c_chg_def     = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GRANT     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_RET_CHG   = 3'd3,
        ST_ACK       = 3'd4,
        ST_FAULT     = 3'd5
    } vend_state_t;

endpackage : vend_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin picker; on contention the side not served
//            last wins.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
    import vend_pkg::*;
(
    input  logic [c_num_req-1:0] req,
    input  logic                 last,
    output logic [c_num_req-1:0] win
);

    assign win[0] = req[0] & (~req[1] | last);
    assign win[1] = req[1] & (~req[0] | ~last);

endmodule : rr_arb2
`default_nettype wire

// File: rtl/vend_dispense_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vend_dispense_arbiter
// Purpose  : Arbitrates two vend requesters onto one dispenser, with change
//            return, dispense timeout fault and round-robin fairness.
// Revision : 1.0 - initial release
// ============================================================================
module vend_dispense_arbiter
    import vend_pkg::*;
#(
    parameter int TIMEOUT_CYC = c_timeout_def,
    parameter int CHG_CYC     = c_chg_def
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [c_num_req-1:0] req,
    input  logic [c_num_req-1:0] chg,
    input  logic                 disp_done,
    input  logic                 fault_clr,
    output logic [c_num_req-1:0] grant,
    output logic                 disp_start,
    output logic                 coin_ret,
    output logic [c_num_req-1:0] ack,
    output logic                 busy,
    output logic                 fault
);

    localparam int c_cw = $clog2(TIMEOUT_CYC) + 1;

    vend_state_t          r_state, w_state_nxt;
    logic [c_cw-1:0]      r_cnt, w_cnt_nxt;
    logic                 r_last, w_last_nxt;
    logic                 r_owner, w_owner_nxt;
    logic                 r_chg, w_chg_nxt;
    logic [c_num_req-1:0] w_win;
    logic [c_num_req-1:0] w_own_oh;

    rr_arb2 u_rr_arb2 (
        .req  (req),
        .last (r_last),
        .win  (w_win)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_last  <= 1'b1;
            r_owner <= 1'b0;
            r_chg   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            r_owner <= w_owner_nxt;
            r_chg   <= w_chg_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_owner_nxt = r_owner;
        w_chg_nxt   = r_chg;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_state_nxt = ST_GRANT;
                    w_owner_nxt = w_win[1];
                    w_chg_nxt   = w_win[1] ? chg[1] : chg[0];
                end
            end
            ST_GRANT: begin
                w_state_nxt = ST_WAIT_DONE;
                w_cnt_nxt   = '0;
            end
            ST_WAIT_DONE: begin
                // A done arriving on the final count still completes normally.
                if (disp_done) begin
                    w_state_nxt = r_chg ? ST_RET_CHG : ST_ACK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cw'(TIMEOUT_CYC - 1)) begin
                    w_state_nxt = ST_FAULT;
                end else begin
                    w_cnt_nxt = r_cnt + c_cw'(1);
                end
            end
            ST_RET_CHG: begin
                if (r_cnt == c_cw'(CHG_CYC - 1)) begin
                    w_state_nxt = ST_ACK;
                end else begin
                    w_cnt_nxt = r_cnt + c_cw'(1);
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
                w_last_nxt  = r_owner;
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_own_oh   = {r_owner, ~r_owner};
    assign grant      = ((r_state == ST_GRANT) || (r_state == ST_WAIT_DONE) ||
                         (r_state == ST_RET_CHG) || (r_state == ST_ACK)) ? w_own_oh : '0;
    assign ack        = (r_state == ST_ACK) ? w_own_oh : '0;
    assign disp_start = (r_state == ST_GRANT);
    assign coin_ret   = (r_state == ST_RET_CHG);
    assign busy       = (r_state != ST_IDLE);
    assign fault      = (r_state == ST_FAULT);

endmodule : vend_dispense_arbiter
`default_nettype wire

// File: tb/tb_vend_dispense_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_dispense_arbiter
// Purpose  : Directed self-checking bench for vend_dispense_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vend_dispense_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [1:0] chg;
    logic       disp_done;
    logic       fault_clr;
    logic [1:0] grant;
    logic       disp_start;
    logic       coin_ret;
    logic [1:0] ack;
    logic       busy;
    logic       fault;

    int n_pass  = 0;
    int n_total = 0;

    vend_dispense_arbiter #(
        .TIMEOUT_CYC (16),
        .CHG_CYC     (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .chg        (chg),
        .disp_done  (disp_done),
        .fault_clr  (fault_clr),
        .grant      (grant),
        .disp_start (disp_start),
        .coin_ret   (coin_ret),
        .ack        (ack),
        .busy       (busy),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full service from IDLE: grant, wait_cyc WAIT_DONE cycles with done on the
    // last one, optional change return, ack, back to IDLE.
    task automatic do_service(input string nm, input logic [1:0] rq, input logic [1:0] cg,
                              input logic [1:0] exp_own, input bit exp_chg,
                              input int wait_cyc, input logic [1:0] rq_after);
        req = rq;
        chg = cg;
        tick();
        n_total++;
        if (grant !== exp_own || disp_start !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL %s grant-phase: grant=%b disp_start=%b busy=%b, want grant=%b 1 1",
                     nm, grant, disp_start, busy, exp_own);
        end else n_pass++;
        for (int i = 0; i < wait_cyc; i++) begin
            tick();
            n_total++;
            if (grant !== exp_own || disp_start !== 1'b0 || ack !== 2'b00 ||
                coin_ret !== 1'b0 || fault !== 1'b0) begin
                $display("FAIL %s wait[%0d]: grant=%b ds=%b ack=%b cr=%b fault=%b, want %b 0 00 0 0",
                         nm, i, grant, disp_start, ack, coin_ret, fault, exp_own);
            end else n_pass++;
        end
        disp_done = 1'b1;
        tick();
        disp_done = 1'b0;
        if (exp_chg) begin
            for (int i = 0; i < 2; i++) begin
                n_total++;
                if (coin_ret !== 1'b1 || ack !== 2'b00 || grant !== exp_own) begin
                    $display("FAIL %s coin_ret[%0d]: cr=%b ack=%b grant=%b, want 1 00 %b",
                             nm, i, coin_ret, ack, grant, exp_own);
                end else n_pass++;
                tick();
            end
        end
        n_total++;
        if (ack !== exp_own || grant !== exp_own || coin_ret !== 1'b0 || fault !== 1'b0) begin
            $display("FAIL %s ack-phase: ack=%b grant=%b cr=%b fault=%b, want ack=%b grant=%b 0 0",
                     nm, ack, grant, coin_ret, fault, exp_own, exp_own);
        end else n_pass++;
        req = rq_after;
        tick();
        n_total++;
        if (busy !== 1'b0 || grant !== 2'b00 || ack !== 2'b00) begin
            $display("FAIL %s idle-return: busy=%b grant=%b ack=%b, want 0 00 00",
                     nm, busy, grant, ack);
        end else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = 2'b00; chg = 2'b00; disp_done = 1'b0; fault_clr = 1'b0;
        tick();
        tick();
        n_total++;
        if (grant !== 2'b00 || disp_start !== 1'b0 || coin_ret !== 1'b0 ||
            ack !== 2'b00 || busy !== 1'b0 || fault !== 1'b0) begin
            $display("FAIL reset_values: grant=%b ds=%b cr=%b ack=%b busy=%b fault=%b, want all 0",
                     grant, disp_start, coin_ret, ack, busy, fault);
        end else n_pass++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        do_service("contend_1st", 2'b11, 2'b00, 2'b01, 1'b0, 2, 2'b10);
        do_service("contend_2nd", 2'b11, 2'b00, 2'b10, 1'b0, 2, 2'b01);
        do_service("contend_3rd", 2'b11, 2'b00, 2'b01, 1'b0, 2, 2'b00);
    endtask

    task automatic test_single();
        do_service("single_req0", 2'b01, 2'b00, 2'b01, 1'b0, 3, 2'b00);
    endtask

    task automatic test_change();
        do_service("change_req1", 2'b10, 2'b10, 2'b10, 1'b1, 2, 2'b00);
        do_service("change_other", 2'b10, 2'b01, 2'b10, 1'b0, 2, 2'b00);
    endtask

    task automatic test_timeout();
        req = 2'b01;
        chg = 2'b00;
        tick();
        for (int i = 0; i < 16; i++) tick();
        n_total++;
        if (fault !== 1'b0 || grant !== 2'b01) begin
            $display("FAIL timeout_last_wait: fault=%b grant=%b, want 0 01", fault, grant);
        end else n_pass++;
        tick();
        n_total++;
        if (fault !== 1'b1 || grant !== 2'b00 || ack !== 2'b00 || busy !== 1'b1) begin
            $display("FAIL timeout_fault: fault=%b grant=%b ack=%b busy=%b, want 1 00 00 1",
                     fault, grant, ack, busy);
        end else n_pass++;
        disp_done = 1'b1;
        tick();
        disp_done = 1'b0;
        tick();
        n_total++;
        if (fault !== 1'b1 || ack !== 2'b00 || grant !== 2'b00) begin
            $display("FAIL fault_hold: fault=%b ack=%b grant=%b, want 1 00 00", fault, ack, grant);
        end else n_pass++;
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        n_total++;
        if (fault !== 1'b0 || busy !== 1'b0 || grant !== 2'b00) begin
            $display("FAIL fault_clear: fault=%b busy=%b grant=%b, want 0 0 00", fault, busy, grant);
        end else n_pass++;
        // Pointer was 1 before the fault; requester 0 must win again.
        do_service("post_fault", 2'b11, 2'b00, 2'b01, 1'b0, 2, 2'b00);
    endtask

    task automatic test_boundary();
        do_service("done_at_timeout", 2'b01, 2'b00, 2'b01, 1'b0, 16, 2'b00);
    endtask

    task automatic test_reset_mid();
        req = 2'b01;
        chg = 2'b00;
        tick();
        tick();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        n_total++;
        if (busy !== 1'b1 || grant !== 2'b01 || fault !== 1'b0) begin
            $display("FAIL clr_ignored: busy=%b grant=%b fault=%b, want 1 01 0", busy, grant, fault);
        end else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++;
        if (grant !== 2'b00 || disp_start !== 1'b0 || coin_ret !== 1'b0 ||
            ack !== 2'b00 || busy !== 1'b0 || fault !== 1'b0) begin
            $display("FAIL async_reset: grant=%b ds=%b cr=%b ack=%b busy=%b fault=%b, want all 0",
                     grant, disp_start, coin_ret, ack, busy, fault);
        end else n_pass++;
        req = 2'b00;
        disp_done = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        disp_done = 1'b0;
        n_total++;
        if (ack !== 2'b00 || busy !== 1'b0) begin
            $display("FAIL late_done: ack=%b busy=%b, want 00 0", ack, busy);
        end else n_pass++;
        do_service("after_reset_rr", 2'b11, 2'b00, 2'b01, 1'b0, 2, 2'b00);
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_change();
        test_timeout();
        test_boundary();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_vend_dispense_arbiter
`default_nettype wire
